hazard_controller: RTL

//  Pipeline sequencer for the 16-bit 5-stage CPU. Sits beside the control unit and drives the stall/flush controls.
//  - Stall/flush controls: PC stop, IF/ID hold/flush, ID/EX bubble, EX hold.
//  - Resolves load-use hazards, taken-branch flushes and multi-cycle mul/div stalls.
//  - Sequences halt: drain the pipeline, then park in HALTED until resume.

---
 rtl/hazard_controller.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch flush, mul/div stall, halt drain.
// Optional HAZARD_PERF_CNT_EN adds stall_cycles_o, a saturating count of non-halted stall cycles.
//
// state     | meaning
// S_RUN     | normal issue, hazards resolved combinationally
// S_MULDIV  | mul/div in flight, front end and EX frozen
// S_DRAIN   | halt retiring through EX/MEM/WB, fetch suppressed
// S_HALTED  | CPU parked until resume
module hazard_controller #(
    parameter int REG_ADDR_W   = 4,
    parameter int MULDIV_LAT   = 4,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                  clock_i,
    input  logic                  reset_ni,
    input  logic                  id_ex_mem_rd_i,
    input  logic [REG_ADDR_W-1:0] id_ex_rd_i,
    input  logic [REG_ADDR_W-1:0] if_id_rs1_i,
    input  logic [REG_ADDR_W-1:0] if_id_rs2_i,
    input  logic                  if_id_uses_rs2_i,
    input  logic                  branch_taken_i,
    input  logic                  muldiv_start_i,
    input  logic                  halt_dec_i,
    input  logic                  resume_i,
    output logic                  pc_stop_o,
    output logic                  if_id_hold_o,
    output logic                  if_id_flush_o,
    output logic                  id_ex_flush_o,
    output logic                  ex_hold_o,
    output logic                  halted_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [15:0]           stall_cycles_o
`endif
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_MULDIV = 2'd1,
        S_DRAIN  = 2'd2,
        S_HALTED = 2'd3
    } state_e;

    localparam logic [7:0] MD_INIT    = 8'(MULDIV_LAT - 1);
    localparam logic [7:0] DRAIN_INIT = 8'(DRAIN_CYCLES);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       load_use;

    // r0 is hard-wired zero, so a load targeting it never creates a dependency
    assign load_use = id_ex_mem_rd_i && (id_ex_rd_i != '0) &&
                      ((if_id_rs1_i == id_ex_rd_i) ||
                       (if_id_uses_rs2_i && (if_id_rs2_i == id_ex_rd_i)));

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_RUN: begin
                if (!branch_taken_i && muldiv_start_i) begin
                    if (MULDIV_LAT > 1) begin
                        cnt_d   = MD_INIT;
                        state_d = S_MULDIV;
                    end
                end else if (!branch_taken_i && !load_use && halt_dec_i) begin
                    cnt_d   = DRAIN_INIT;
                    state_d = S_DRAIN;
                end
            end
            S_MULDIV: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q <= 8'd1) state_d = S_RUN;
            end
            S_DRAIN: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q <= 8'd1) state_d = S_HALTED;
            end
            S_HALTED: begin
                if (resume_i) state_d = S_RUN;
            end
            default: begin
                state_d = S_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are forced low for as long as reset is held, whatever the inputs do
    always_comb begin
        pc_stop_o     = 1'b0;
        if_id_hold_o  = 1'b0;
        if_id_flush_o = 1'b0;
        id_ex_flush_o = 1'b0;
        ex_hold_o     = 1'b0;
        halted_o      = 1'b0;
        if (reset_ni) begin
            case (state_q)
                S_RUN: begin
                    if (branch_taken_i) begin
                        if_id_flush_o = 1'b1;
                        id_ex_flush_o = 1'b1;
                    end else if (muldiv_start_i) begin
                        pc_stop_o    = 1'b1;
                        if_id_hold_o = 1'b1;
                        ex_hold_o    = 1'b1;
                    end else if (load_use) begin
                        pc_stop_o     = 1'b1;
                        if_id_hold_o  = 1'b1;
                        id_ex_flush_o = 1'b1;
                    end else if (halt_dec_i) begin
                        pc_stop_o     = 1'b1;
                        if_id_flush_o = 1'b1;
                    end
                end
                S_MULDIV: begin
                    pc_stop_o    = 1'b1;
                    if_id_hold_o = 1'b1;
                    ex_hold_o    = 1'b1;
                end
                S_DRAIN: begin
                    pc_stop_o     = 1'b1;
                    if_id_flush_o = 1'b1;
                end
                S_HALTED: begin
                    pc_stop_o     = 1'b1;
                    if_id_flush_o = 1'b1;
                    halted_o      = 1'b1;
                end
                default: begin
                    pc_stop_o = 1'b0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            stall_cnt_q <= '0;
        end else if (pc_stop_o && (state_q != S_HALTED) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cycles_o = stall_cnt_q;
`endif

endmodule
